// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin arbiter that shares one memory bus between MASTERS masters.
//   A grant is held until the slave answers (ready/fault) or the watchdog
//   forces a fault after TIMEOUT busy cycles (TIMEOUT = 0 disables it).
//
// Ports
//   clk, reset          : system clock, asynchronous active-high reset
//   m_*_in / m_*_out    : per-master bus, master i in slice i of each vector
//   *_out (common)      : bus toward the slave, driven only while BUSY
//   read_value_in       : slave read data
//   ready_in, fault_in  : slave completion / fault
//   grant_out           : one-hot grant while BUSY, 0 otherwise
//   busy_out            : high while a transaction is in flight
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant; pick next requester starting from ptr
// BUSY  | master g owns the bus; wait for ready/fault or watchdog
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int MASTERS   = 2,
  parameter int TIMEOUT   = 255,
  parameter int PTR_WIDTH = $clog2(MASTERS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [MASTERS*32-1:0]   m_address_in,
  input  logic [MASTERS-1:0]      m_read_in,
  input  logic [MASTERS-1:0]      m_write_in,
  input  logic [MASTERS*4-1:0]    m_write_mask_in,
  input  logic [MASTERS*32-1:0]   m_write_value_in,
  output logic [MASTERS*32-1:0]   m_read_value_out,
  output logic [MASTERS-1:0]      m_ready_out,
  output logic [MASTERS-1:0]      m_fault_out,
  output logic [31:0]             address_out,
  output logic                    read_out,
  output logic                    write_out,
  output logic [3:0]              write_mask_out,
  output logic [31:0]             write_value_out,
  input  logic [31:0]             read_value_in,
  input  logic                    ready_in,
  input  logic                    fault_in,
  output logic [MASTERS-1:0]      grant_out,
  output logic                    busy_out
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [PTR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [PTR_WIDTH-1:0]   g_q, g_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [MASTERS-1:0]     req;
  logic [PTR_WIDTH-1:0]   sel, sel_hi, sel_lo;
  logic                   sel_vld, hi_vld, lo_vld;
  logic                   resp, tmo;

  assign req  = m_read_in | m_write_in;
  assign resp = (state_q == BUSY) & (ready_in | fault_in);
  // A slave answer in the watchdog cycle takes precedence over the timeout.
  assign tmo  = (state_q == BUSY) & (TIMEOUT != 0) & (cnt_q == CNT_MAX)
              & ~ready_in & ~fault_in;

  // Rotating priority: lowest requester at or above ptr, else lowest overall.
  // Loops run high-to-low so the last hit is the lowest index.
  always_comb begin
    sel_hi = '0;
    sel_lo = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_lo = PTR_WIDTH'(i);
        lo_vld = 1'b1;
        if (PTR_WIDTH'(i) >= ptr_q) begin
          sel_hi = PTR_WIDTH'(i);
          hi_vld = 1'b1;
        end
      end
    end
    sel     = hi_vld ? sel_hi : sel_lo;
    sel_vld = lo_vld;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          g_d     = sel;
          cnt_d   = CNT_W'(1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (resp || tmo) begin
          state_d = IDLE;
          ptr_d   = (g_q == PTR_WIDTH'(MASTERS - 1)) ? '0 : g_q + 1'b1;
          cnt_d   = '0;
        end else if ((TIMEOUT != 0) && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    address_out      = '0;
    read_out         = 1'b0;
    write_out        = 1'b0;
    write_mask_out   = '0;
    write_value_out  = '0;
    grant_out        = '0;
    m_ready_out      = '0;
    m_fault_out      = '0;
    m_read_value_out = '0;
    busy_out         = (state_q == BUSY);
    if (state_q == BUSY) begin
      for (int i = 0; i < MASTERS; i++) begin
        if (g_q == PTR_WIDTH'(i)) begin
          address_out                 = m_address_in[32*i +: 32];
          read_out                    = m_read_in[i];
          write_out                   = m_write_in[i];
          write_mask_out              = m_write_mask_in[4*i +: 4];
          write_value_out             = m_write_value_in[32*i +: 32];
          grant_out[i]                = 1'b1;
          m_ready_out[i]              = resp | tmo;
          m_fault_out[i]              = (resp & fault_in) | tmo;
          m_read_value_out[32*i +: 32] = resp ? read_value_in : 32'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // dut_a: MASTERS=2 (default), TIMEOUT=4
  logic        reset_a;
  logic [63:0] a_addr, a_wval, a_rval_o;
  logic [1:0]  a_rd, a_wr, a_rdy_o, a_flt_o, a_grant_o;
  logic [7:0]  a_mask;
  logic [31:0] a_addr_o, a_wval_o, a_rval_i;
  logic        a_rd_o, a_wr_o, a_ready_i, a_fault_i, a_busy_o;
  logic [3:0]  a_mask_o;

  // dut_b: MASTERS=3, TIMEOUT=0 (watchdog off)
  logic        reset_b;
  logic [95:0] b_addr, b_wval, b_rval_o;
  logic [2:0]  b_rd, b_wr, b_rdy_o, b_flt_o, b_grant_o;
  logic [11:0] b_mask;
  logic [31:0] b_addr_o, b_wval_o, b_rval_i;
  logic        b_rd_o, b_wr_o, b_ready_i, b_fault_i, b_busy_o;
  logic [3:0]  b_mask_o;

  // Grant sequence with both masters of dut_a requesting, ptr=1 at start.
  logic [1:0] exp_g [8] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

  bus_arbiter_rr #(.TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset_a),
    .m_address_in(a_addr), .m_read_in(a_rd), .m_write_in(a_wr),
    .m_write_mask_in(a_mask), .m_write_value_in(a_wval),
    .m_read_value_out(a_rval_o), .m_ready_out(a_rdy_o), .m_fault_out(a_flt_o),
    .address_out(a_addr_o), .read_out(a_rd_o), .write_out(a_wr_o),
    .write_mask_out(a_mask_o), .write_value_out(a_wval_o),
    .read_value_in(a_rval_i), .ready_in(a_ready_i), .fault_in(a_fault_i),
    .grant_out(a_grant_o), .busy_out(a_busy_o)
  );

  bus_arbiter_rr #(.MASTERS(3), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset_b),
    .m_address_in(b_addr), .m_read_in(b_rd), .m_write_in(b_wr),
    .m_write_mask_in(b_mask), .m_write_value_in(b_wval),
    .m_read_value_out(b_rval_o), .m_ready_out(b_rdy_o), .m_fault_out(b_flt_o),
    .address_out(b_addr_o), .read_out(b_rd_o), .write_out(b_wr_o),
    .write_mask_out(b_mask_o), .write_value_out(b_wval_o),
    .read_value_in(b_rval_i), .ready_in(b_ready_i), .fault_in(b_fault_i),
    .grant_out(b_grant_o), .busy_out(b_busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    a_addr = '0; a_wval = '0; a_rd = '0; a_wr = '0; a_mask = '0;
    a_rval_i = '0; a_ready_i = 1'b0; a_fault_i = 1'b0;
    b_addr = '0; b_wval = '0; b_rd = '0; b_wr = '0; b_mask = '0;
    b_rval_i = '0; b_ready_i = 1'b0; b_fault_i = 1'b0;
    a_rd = 2'b01; a_addr[31:0] = 32'h100;

    // reset: outputs quiet even with a request present
    cyc(); #1;
    chk("rst_busy_a",  32'(a_busy_o),  32'h0);
    chk("rst_grant_a", 32'(a_grant_o), 32'h0);
    chk("rst_read_a",  32'(a_rd_o),    32'h0);
    chk("rst_addr_a",  a_addr_o,       32'h0);
    chk("rst_busy_b",  32'(b_busy_o),  32'h0);
    a_rd = 2'b00; reset_a = 1'b0;

    // single read, zero-wait slave
    cyc(); a_rd = 2'b01; a_addr[31:0] = 32'h100; #1;
    chk("t1_c0_busy",  32'(a_busy_o), 32'h0);
    chk("t1_c0_read",  32'(a_rd_o),   32'h0);
    cyc(); a_rval_i = 32'hDEADBEEF; a_ready_i = 1'b1; #1;
    chk("t1_addr",     a_addr_o,          32'h100);
    chk("t1_read",     32'(a_rd_o),       32'h1);
    chk("t1_grant",    32'(a_grant_o),    32'h1);
    chk("t1_ready",    32'(a_rdy_o),      32'h1);
    chk("t1_fault",    32'(a_flt_o),      32'h0);
    chk("t1_rval0",    a_rval_o[31:0],    32'hDEADBEEF);
    chk("t1_rval1",    a_rval_o[63:32],   32'h0);
    cyc(); a_rd = 2'b00; a_ready_i = 1'b0; a_rval_i = '0; #1;
    chk("t1_idle_busy",  32'(a_busy_o),  32'h0);
    chk("t1_idle_grant", 32'(a_grant_o), 32'h0);

    // both masters continuously, ptr=1 after the previous grant of master 0
    a_rd = 2'b11; a_addr = {32'h200, 32'h100}; a_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(); #1;
      chk($sformatf("t2_grant_%0d", k), 32'(a_grant_o), 32'(exp_g[k]));
      chk($sformatf("t2_ready_%0d", k), 32'(a_rdy_o),   32'(exp_g[k]));
      if (k == 0) chk("t2_addr_m1", a_addr_o, 32'h200);
    end

    // watchdog: master 0 writes, slave silent; ptr=1
    a_rd = 2'b00; a_wr = 2'b01; a_addr[31:0] = 32'h104; a_mask[3:0] = 4'hA;
    a_wval[31:0] = 32'hCAFE0001; a_ready_i = 1'b0; a_rval_i = 32'h12345678;
    for (int k = 1; k <= 4; k++) begin
      cyc(); #1;
      chk($sformatf("t4_busy_%0d", k),  32'(a_busy_o), 32'h1);
      chk($sformatf("t4_ready_%0d", k), 32'(a_rdy_o),  (k == 4) ? 32'h1 : 32'h0);
      chk($sformatf("t4_fault_%0d", k), 32'(a_flt_o),  (k == 4) ? 32'h1 : 32'h0);
      if (k == 1) begin
        chk("t4_write", 32'(a_wr_o),   32'h1);
        chk("t4_mask",  32'(a_mask_o), 32'hA);
        chk("t4_wval",  a_wval_o,      32'hCAFE0001);
      end
      if (k == 4) chk("t4_rval_zero", a_rval_o[31:0], 32'h0);
    end
    cyc(); a_wr = 2'b00; #1;
    chk("t4_idle", 32'(a_busy_o), 32'h0);

    // ready+fault together, master 1 (ptr=1)
    a_rd = 2'b10; a_addr[63:32] = 32'h208; a_ready_i = 1'b1; a_fault_i = 1'b1;
    cyc(); #1;
    chk("t5_grant", 32'(a_grant_o), 32'h2);
    chk("t5_ready", 32'(a_rdy_o),   32'h2);
    chk("t5_fault", 32'(a_flt_o),   32'h2);
    cyc(); a_rd = 2'b00; a_ready_i = 1'b0; a_fault_i = 1'b0; #1;
    chk("t5_idle", 32'(a_busy_o), 32'h0);

    // slave answers exactly in the watchdog cycle: no forced fault (ptr=0)
    a_rd = 2'b01; a_addr[31:0] = 32'h10C; a_rval_i = 32'h5A5A5A5A;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 4) a_ready_i = 1'b1;
      #1;
      chk($sformatf("t5b_ready_%0d", k), 32'(a_rdy_o), (k == 4) ? 32'h1 : 32'h0);
      chk($sformatf("t5b_fault_%0d", k), 32'(a_flt_o), 32'h0);
    end
    chk("t5b_rval", a_rval_o[31:0], 32'h5A5A5A5A);
    cyc(); a_rd = 2'b00; a_ready_i = 1'b0; #1;
    chk("t5b_idle", 32'(a_busy_o), 32'h0);

    // async reset mid-BUSY (ptr=1 before reset)
    a_rd = 2'b01; a_addr[31:0] = 32'h110;
    cyc(); #1;
    chk("t6_busy_pre",  32'(a_busy_o),  32'h1);
    chk("t6_grant_pre", 32'(a_grant_o), 32'h1);
    a_rd = 2'b11; a_addr[63:32] = 32'h214; a_ready_i = 1'b1;
    #1 reset_a = 1'b1;
    #1;
    chk("t6_rst_busy",  32'(a_busy_o),  32'h0);
    chk("t6_rst_grant", 32'(a_grant_o), 32'h0);
    chk("t6_rst_ready", 32'(a_rdy_o),   32'h0);
    chk("t6_rst_addr",  a_addr_o,       32'h0);
    chk("t6_rst_read",  32'(a_rd_o),    32'h0);
    chk("t6_rst_rval",  a_rval_o[31:0], 32'h0);
    #2 reset_a = 1'b0;
    cyc(); #1;
    chk("t6_post_grant", 32'(a_grant_o), 32'h1);
    chk("t6_post_addr",  a_addr_o,       32'h110);
    cyc(); a_rd = 2'b00; a_ready_i = 1'b0; #1;
    chk("t6_post_idle", 32'(a_busy_o), 32'h0);

    // three masters: only master 2, then 0 and 1 together
    cyc(); reset_b = 1'b0;
    b_rd = 3'b100; b_addr[95:64] = 32'h300; b_rval_i = 32'h33333333; b_ready_i = 1'b1; #1;
    chk("t3_c0_busy", 32'(b_busy_o), 32'h0);
    cyc(); #1;
    chk("t3_grant_m2", 32'(b_grant_o),  32'h4);
    chk("t3_addr_m2",  b_addr_o,        32'h300);
    chk("t3_ready_m2", 32'(b_rdy_o),    32'h4);
    chk("t3_rval_m2",  b_rval_o[95:64], 32'h33333333);
    chk("t3_rval_m0",  b_rval_o[31:0],  32'h0);
    cyc(); b_rd = 3'b011; b_addr[31:0] = 32'h010; b_addr[63:32] = 32'h020; #1;
    chk("t3_gap1", 32'(b_busy_o), 32'h0);
    cyc(); #1;
    chk("t3_grant_m0", 32'(b_grant_o), 32'h1);
    chk("t3_addr_m0",  b_addr_o,       32'h010);
    cyc(); b_rd = 3'b010; #1;
    chk("t3_gap2", 32'(b_busy_o), 32'h0);
    cyc(); #1;
    chk("t3_grant_m1", 32'(b_grant_o), 32'h2);
    cyc(); b_rd = 3'b000; b_ready_i = 1'b0; #1;
    chk("t3_idle", 32'(b_busy_o), 32'h0);

    // watchdog disabled: silent slave keeps the grant
    b_wr = 3'b010; b_addr[63:32] = 32'h024;
    for (int k = 1; k <= 12; k++) begin
      cyc(); #1;
      chk($sformatf("t4z_busy_%0d", k),  32'(b_busy_o), 32'h1);
      chk($sformatf("t4z_ready_%0d", k), 32'(b_rdy_o),  32'h0);
    end
    b_ready_i = 1'b1; #1;
    chk("t4z_grant", 32'(b_grant_o), 32'h2);
    chk("t4z_ready", 32'(b_rdy_o),   32'h2);
    chk("t4z_fault", 32'(b_flt_o),   32'h0);
    cyc(); b_wr = 3'b000; b_ready_i = 1'b0; #1;
    chk("t4z_idle", 32'(b_busy_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
N-master round-robin arbiter for the shared memory bus. It supersedes the fixed two-port instruction/data arbiter with a generalised version. Each master port carries the standard address/read/write/mask/value/ready/fault bus. One master at a time is granted the common bus; the grant is locked until the slave completes. A watchdog converts a non-responding slave into a bus fault, so a hung peripheral cannot stall the core.

Parameters:
MASTERS, 2, number of master ports (>=2)
TIMEOUT, 255, max BUSY cycles before forced fault (0 = watchdog disabled)
PTR_WIDTH, $clog2(MASTERS), width of internal pointer/grant index (derived, do not override)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m_address_in  in  MASTERS*32  per-master address, master i at [32i+31:32i]
m_read_in  in  MASTERS  per-master read request
m_write_in  in  MASTERS  per-master write request
m_write_mask_in  in  MASTERS*4  per-master byte write mask
m_write_value_in  in  MASTERS*32  per-master write data
m_read_value_out  out  MASTERS*32  per-master read data
m_ready_out  out  MASTERS  per-master completion strobe
m_fault_out  out  MASTERS  per-master fault strobe, valid with ready
address_out  out  32  common bus address
read_out  out  1  common bus read
write_out  out  1  common bus write
write_mask_out  out  4  common bus byte mask
write_value_out  out  32  common bus write data
read_value_in  in  32  common bus read data
ready_in  in  1  slave completion
fault_in  in  1  slave/decoder fault
grant_out  out  MASTERS  one-hot current grant (debug/perf)
busy_out  out  1  state == BUSY

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high.
- Reset: state IDLE, ptr=0, grant index=0, watchdog count=0.
- All outputs are 0 during and immediately after reset, including mid-transaction.
- Request: req[i] = m_read_in[i] | m_write_in[i].
- A master holds all of its signals stable from request until it sees its m_ready_out.
- IDLE state:
  - Common bus outputs are all 0; grant_out=0.
  - If req!=0, select the first i with req[i]=1, searching ptr, ptr+1, ... MASTERS-1, 0, ... (wrapping).
  - Register the selection as g and go to BUSY next cycle.
  - If req==0, stay in IDLE.
- BUSY state:
  - Common bus outputs pass through combinationally from master g; grant_out=1<<g.
  - Watchdog count increments each BUSY cycle, starting at 1 in the first BUSY cycle.
- Completion (BUSY only), in the same cycle:
  - On ready_in | fault_in: m_ready_out[g]=1 and m_fault_out[g]=fault_in.
  - m_read_value_out[g]=read_value_in.
  - Next cycle: IDLE, ptr=(g+1) mod MASTERS, count=0.
- Timeout: when TIMEOUT!=0, count==TIMEOUT and ready_in=fault_in=0:
  - m_ready_out[g]=1 and m_fault_out[g]=1 that cycle; read value is 0.
  - Then IDLE with the same ptr update as a normal completion.
- Priority of events:
  - fault_in together with ready_in gives fault=1.
  - A slave response in the timeout cycle wins over the timeout, so no forced fault.
- Non-granted masters always see m_ready_out=0, m_fault_out=0, m_read_value_out=0.
- Latency:
  - Request to bus is 1 cycle; a zero-wait slave completes in the first BUSY cycle.
  - Minimum 2 cycles per transaction, with one IDLE cycle between grants.
- Dropped request mid-BUSY is a protocol violation. The grant still holds until completion or timeout; the bus then carries master g's current (possibly idle) signals.
- ptr changes only on completion or timeout, so an uninterrupted requester cannot starve others. Worst-case wait is (MASTERS-1) transactions.

Test Plan:
1. MASTERS=2: master 0 reads 0x00000100 at cycle 0; slave ready_in in first BUSY cycle with read_value_in=0xDEADBEEF -> address_out=0x100 and read_out=1 at cycle 1, m_ready_out[0]=1 with 0xDEADBEEF at cycle 1, m_read_value_out[1]=0, IDLE at cycle 2.
2. MASTERS=2: both masters request continuously with a zero-wait slave -> grant_out sequence 01,10,01,10, one grant every 2 cycles, no starvation.
3. MASTERS=3, ptr=0: only master 2 requests -> grant_out=100; after completion ptr=0 and a simultaneous request from masters 0 and 1 grants 0 first.
4. TIMEOUT=4: slave never responds -> busy_out high for exactly 4 cycles; in the 4th, m_ready_out[g]=1 and m_fault_out[g]=1; IDLE next cycle. TIMEOUT=0 with the same stimulus -> stays BUSY indefinitely.
5. ready_in=1 and fault_in=1 in the same cycle -> m_ready_out[g]=1, m_fault_out[g]=1. With TIMEOUT=4, ready_in=1 exactly on the 4th BUSY cycle -> m_fault_out=0.
6. reset asserted asynchronously mid-BUSY (between clock edges) -> all outputs 0 before the next edge; after release, first grant search starts at master 0.
